vector_ex_unit: RTL and testbench
=================================

// Module: vector_ex_unit
// PURPOSE
//   Execute-stage vector ALU, directly downstream of the ID/EX pipeline register.
//   Consumes RD1V_ex/RD2V_ex, ALUOpV_ex, RD2S_ex and operand_flag_ex.
//   Processes LANES x WIDTH vectors over several cycles, LPC lanes per cycle, so
//   the multiplier stays small. Requests a pipeline stall while busy.
// PARAMETERS
//   LANES  16  number of vector lanes
//   WIDTH  16  bits per lane
//   LPC     4  lanes computed per cycle; must divide LANES (elaboration error otherwise)
// PORTS
//   clk        in   1              clock; all state updates on rising edge
//   rst        in   1              reset, asynchronous, active-high
//   start      in   1              request a vector op (from RegWriteV_ex/decode)
//   flush      in   1              abort the op in flight (branch taken)
//   alu_op     in   3              op code (ALUOpV_ex)
//   scalar_sel in   1              1: operand B = scalar_b broadcast (operand_flag_ex)
//   src_a      in   LANES*WIDTH    operand A, packed [LANES-1:0][WIDTH-1:0]
//   src_b      in   LANES*WIDTH    operand B, packed as src_a
//   scalar_b   in   19             scalar operand; only [WIDTH-1:0] used
//   result     out  LANES*WIDTH    result vector register
//   busy       out  1              op in progress (state RUN)
//   done       out  1              one-cycle pulse: result complete
//   stall_req  out  1              hold the upstream pipeline registers
// BEHAVIOUR
//   Reset: state=IDLE; result=0; busy=0; done=0; lane_idx=0; captured operands=0.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 -> capture alu_op, src_a, and the effective B into
//     op_q/a_q/b_q; lane_idx=0; go to RUN. Otherwise stay in IDLE.
//   - RUN: each edge writes result lanes [lane_idx +: LPC]; lane_idx += LPC.
//     The edge that writes the last group (lane_idx = LANES-LPC) goes to DONE.
//     start is ignored in RUN.
//   - DONE: done=1 for this cycle only. start=1 -> capture and go to RUN
//     (back-to-back op); otherwise go to IDLE.
//   Latency: start sampled at edge E0; groups written at E1..E(LANES/LPC);
//     done=1 during the cycle following E(LANES/LPC). Default is 4 RUN cycles.
//   Effective B = scalar_sel ? {LANES{scalar_b[WIDTH-1:0]}} : src_b. Captured at start.
//     Later input changes have no effect on the op in flight.
//   Ops (per lane, unsigned, results mod 2^WIDTH):
//     000 add | 001 sub (a-b, wraps) | 010 mul (low WIDTH bits)
//     011 and | 100 or | 101 xor
//     110 shl by b[3:0] | 111 shr logical by b[3:0]
//   Result lanes not yet written in the current op keep their previous values.
//     result holds its value after DONE until the next op overwrites it.
//   stall_req = (state==IDLE & start & !flush) | (state==DONE & start & !flush)
//     | (state==RUN). This is combinational, so the ID/EX register holds through the op.
//   busy = (state==RUN).
//   flush: in any state, flush=1 at an edge -> IDLE, lane_idx=0, done=0.
//     Partially written result lanes remain. flush together with start: flush wins
//     and nothing is captured.
//   rst asserted mid-op: immediate return to reset values; no done pulse.
// TESTING
//   1. add, a lanes=i, b lanes=100 -> after 4 RUN cycles done=1, lane i=100+i,
//      stall_req high for exactly 5 cycles from start (E0 to E4).
//   2. sub, scalar_sel=1, scalar_b=0x00005, a lanes=3 -> every lane=0xFFFE (wrap);
//      src_b contents ignored.
//   3. mul a=0x0100, b=0x0100 -> 0x0000; shl a=0x0001, b=0x0013 -> 0x0008
//      (shift uses b[3:0]=3).
//   4. start held high across DONE -> second op begins with no IDLE cycle;
//      two done pulses 5 cycles apart.
//   5. flush after 2 RUN cycles -> IDLE next edge, done never pulses,
//      lanes 0-7 new, lanes 8-15 old.
//   6. rst pulsed mid-RUN (asynchronous, between edges) -> result=0, busy=0,
//      stall_req=0 immediately.

Source files
------------

// File: rtl/vector_ex_unit.sv
// Execute-stage vector ALU: runs LANES x WIDTH ops LPC lanes per cycle,
// holding the upstream pipeline through a stall request while it works.
module vector_ex_unit #(
  parameter int unsigned LANES = 16,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LPC   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         flush,
  input  logic [2:0]                   alu_op,
  input  logic                         scalar_sel,
  input  logic [LANES-1:0][WIDTH-1:0]  src_a,
  input  logic [LANES-1:0][WIDTH-1:0]  src_b,
  input  logic [18:0]                  scalar_b,
  output logic [LANES-1:0][WIDTH-1:0]  result,
  output logic                         busy,
  output logic                         done,
  output logic                         stall_req
);

  localparam int unsigned IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LAST_IDX = LANES - LPC;

  if ((LPC == 0) || ((LANES % LPC) != 0)) begin : g_bad_lpc
    $error("vector_ex_unit: LPC must divide LANES");
  end
  if ((WIDTH < 4) || (WIDTH > 19)) begin : g_bad_width
    $error("vector_ex_unit: WIDTH must be in 4..19");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [2:0]                    op_q, op_d;
  logic [LANES-1:0][WIDTH-1:0]   a_q, a_d;
  logic [LANES-1:0][WIDTH-1:0]   b_q, b_d;
  logic [LANES-1:0][WIDTH-1:0]   result_q, result_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [LANES-1:0][WIDTH-1:0]   eff_b;
  logic                          unused_scalar;

  // Only the low WIDTH bits of the scalar participate.
  assign unused_scalar = ^scalar_b;

  function automatic logic [WIDTH-1:0] lane_alu(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a * b;
      3'b011: r = a & b;
      3'b100: r = a | b;
      3'b101: r = a ^ b;
      3'b110: r = a << b[3:0];
      3'b111: r = a >> b[3:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      eff_b[i] = scalar_sel ? scalar_b[WIDTH-1:0] : src_b[i];
    end
  end

  // Next-state: flush overrides everything, including a simultaneous start.
  always_comb begin
    logic [IDX_W-1:0] lane;
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    result_d = result_q;
    lane     = '0;

    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            op_d    = alu_op;
            a_d     = src_a;
            b_d     = eff_b;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          for (int g = 0; g < int'(LPC); g++) begin
            lane           = idx_q + IDX_W'(g);
            result_d[lane] = lane_alu(op_q, a_q[lane], b_q[lane]);
          end
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(LPC);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  // Combinational so the ID/EX register freezes in the same cycle start is seen.
  assign stall_req = (state_q == ST_RUN)
                   | ((state_q != ST_RUN) & start & ~flush);

endmodule

// File: tb/tb_vector_ex_unit.sv
// Bench for vector_ex_unit: a lane-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vector_ex_unit;

  localparam int unsigned LANES = 16;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned LPC   = 4;
  localparam int unsigned NG    = LANES / LPC;
  localparam int unsigned VW    = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, flush, scalar_sel;
  logic [2:0]    alu_op;
  logic [VW-1:0] src_a, src_b, result;
  logic [18:0]   scalar_b;
  logic          busy, done, stall_req;

  int n_vec = 0;
  int n_err = 0;

  vector_ex_unit #(.LANES(LANES), .WIDTH(WIDTH), .LPC(LPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .alu_op    (alu_op),
    .scalar_sel(scalar_sel),
    .src_a     (src_a),
    .src_b     (src_b),
    .scalar_b  (scalar_b),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                               input int unsigned a,
                                               input int unsigned b);
    int unsigned r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = a << (b % 16);
      default: r = a >> (b % 16);
    endcase
    return WIDTH'(r);
  endfunction

  // Transaction model: whole answer computed at capture, committed one group per edge.
  logic [VW-1:0]    mdl_res    = '0;
  logic [WIDTH-1:0] mdl_full [LANES];
  bit               mdl_active = 1'b0;
  bit               mdl_done   = 1'b0;
  int               mdl_groups = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_res    <= '0;
      mdl_active <= 1'b0;
      mdl_done   <= 1'b0;
      mdl_groups <= 0;
    end else if (flush) begin
      mdl_active <= 1'b0;
      mdl_done   <= 1'b0;
    end else if (mdl_active) begin
      for (int g = 0; g < int'(LPC); g++) begin
        mdl_res[(mdl_groups*LPC+g)*WIDTH +: WIDTH] <= mdl_full[mdl_groups*LPC+g];
      end
      mdl_groups <= mdl_groups + 1;
      if (mdl_groups == int'(NG) - 1) begin
        mdl_active <= 1'b0;
        mdl_done   <= 1'b1;
      end else begin
        mdl_done <= 1'b0;
      end
    end else begin
      mdl_done <= 1'b0;
      if (start) begin
        for (int l = 0; l < int'(LANES); l++) begin
          mdl_full[l] <= ref_alu(alu_op, src_a[l*WIDTH +: WIDTH],
                                 scalar_sel ? scalar_b[WIDTH-1:0] : src_b[l*WIDTH +: WIDTH]);
        end
        mdl_active <= 1'b1;
        mdl_groups <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("result", result, mdl_res);
      chk("busy", VW'(busy), VW'(mdl_active));
      chk("done", VW'(done), VW'(mdl_done));
      chk("stall_req", VW'(stall_req), VW'(mdl_active | (start & ~flush)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_timeout", VW'(seen), VW'(1));
    tick();
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
  endtask

  task automatic fill(output logic [VW-1:0] v, input int unsigned lane_val);
    for (int i = 0; i < int'(LANES); i++) v[i*WIDTH +: WIDTH] = WIDTH'(lane_val);
  endtask

  task automatic rand_vec(output logic [VW-1:0] v);
    for (int w = 0; w < int'(VW / 32); w++) v[w*32 +: 32] = $urandom;
  endtask

  logic [VW-1:0] exp_v;
  int            stall_cnt, d1, d2;
  bit            seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; scalar_sel = 1'b0;
    src_a = '0; src_b = '0; scalar_b = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_result", result, '0);
    chk("reset_busy", VW'(busy), '0);
    chk("reset_done", VW'(done), '0);
    chk("reset_stall", VW'(stall_req), '0);
    rst = 1'b0;
    tick();

    // add, lane i = i + 100; stall spans start cycle plus four RUN cycles
    for (int i = 0; i < int'(LANES); i++) begin
      src_a[i*WIDTH +: WIDTH] = WIDTH'(i);
      exp_v[i*WIDTH +: WIDTH] = WIDTH'(100 + i);
    end
    fill(src_b, 100);
    alu_op = 3'd0;
    start  = 1'b1;
    stall_cnt = 0; d1 = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      stall_cnt += int'(stall_req);
      if (done && d1 < 0) d1 = k;
      tick();
      start = 1'b0;
    end
    chk("t1_stall_cycles", VW'(stall_cnt), VW'(5));
    chk("t1_done_cycle", VW'(d1), VW'(5));
    chk("t1_result", result, exp_v);

    // scalar broadcast sub wraps; src_b ignored
    alu_op = 3'd1; scalar_sel = 1'b1; scalar_b = 19'h00005;
    fill(src_a, 3); rand_vec(src_b);
    go();
    fill(exp_v, 16'hFFFE);
    chk("t2_sub_scalar", result, exp_v);
    scalar_sel = 1'b0;

    alu_op = 3'd2; fill(src_a, 16'h0100); fill(src_b, 16'h0100);
    go();
    chk("t3_mul_low", result, '0);

    alu_op = 3'd6; fill(src_a, 16'h0001); fill(src_b, 16'h0013);
    go();
    fill(exp_v, 16'h0008);
    chk("t3_shl_low4", result, exp_v);

    // flush after two RUN cycles: half written, no done
    alu_op = 3'd0; fill(src_b, 16'h1000);
    for (int i = 0; i < int'(LANES); i++) begin
      src_a[i*WIDTH +: WIDTH] = WIDTH'(i);
      exp_v[i*WIDTH +: WIDTH] = (i < 8) ? WIDTH'(16'h1000 + i) : WIDTH'(16'h0008);
    end
    start = 1'b1; seen_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      tick();
      if (k == 0) start = 1'b0;
      if (k == 2) flush = 1'b1;
      if (k == 3) flush = 1'b0;
    end
    chk("t5_no_done", VW'(seen_done), '0);
    chk("t5_partial", result, exp_v);

    start = 1'b1; flush = 1'b1;
    tick();
    chk("flush_beats_start", VW'(busy), '0);
    start = 1'b0; flush = 1'b0;
    tick();

    // start held across DONE: back-to-back ops, inputs changed mid-flight
    alu_op = 3'd5; rand_vec(src_a); rand_vec(src_b);
    start = 1'b1; d1 = -1; d2 = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      tick();
      if (k == 1) begin
        alu_op = 3'd4;
        rand_vec(src_a);
      end
      if (k == 5) start = 1'b0;
    end
    chk("t4_first_done", VW'(d1), VW'(5));
    chk("t4_second_done", VW'(d2), VW'(10));
    chk("t4_or_result", result, src_a | src_b);

    // async reset between edges mid-RUN
    alu_op = 3'd0; rand_vec(src_a); rand_vec(src_b);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_result", result, '0);
    chk("t6_rst_busy", VW'(busy), '0);
    chk("t6_rst_stall", VW'(stall_req), '0);
    #2;
    rst = 1'b0;
    tick();
    chk("t6_no_done", VW'(done), '0);

    for (int c = 0; c < 400; c++) begin
      start      = ($urandom % 3) == 0;
      flush      = ($urandom % 16) == 0;
      alu_op     = 3'($urandom);
      scalar_sel = 1'($urandom);
      scalar_b   = 19'($urandom);
      rand_vec(src_a);
      rand_vec(src_b);
      if ($urandom % 2 == 1) begin
        for (int i = 0; i < int'(LANES); i++) src_b[i*WIDTH +: WIDTH] = WIDTH'($urandom % 20);
      end
      tick();
    end
    start = 1'b0; flush = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
